// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall/flush controller with memory-wait FSM and stall counter.
// Define FORWARDING_EN to enable the EX-stage forwarding unit (load-use stalls only).
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif

module hazard_ctrl #(
    parameter int MEM_TIMEOUT     = 64,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [`REG_FILE_DEPTH-1:0]   id_src1,
    input  logic [`REG_FILE_DEPTH-1:0]   id_src2,
    input  logic                         id_two_src,
    input  logic [`REG_FILE_DEPTH-1:0]   ex_dst,
    input  logic                         ex_wb_en,
    input  logic                         ex_mem_read,
    input  logic                         ex_branch,
    input  logic [`REG_FILE_DEPTH-1:0]   ex_src1,
    input  logic [`REG_FILE_DEPTH-1:0]   ex_src2,
    input  logic [`REG_FILE_DEPTH-1:0]   mem_dst,
    input  logic                         mem_wb_en,
    input  logic [`REG_FILE_DEPTH-1:0]   wb_dst,
    input  logic                         wb_wb_en,
    input  logic                         mem_req,
    input  logic                         mem_ready,
    output logic                         freeze,
    output logic                         flush_if,
    output logic                         flush_id,
    output logic                         freeze_mem,
    output logic [1:0]                   fwd_sel1,
    output logic [1:0]                   fwd_sel2,
    output logic                         mem_error,
    output logic [STALL_CNT_WIDTH-1:0]   stall_cycles
);

    localparam int REG_W  = `REG_FILE_DEPTH;
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, ERROR} state_t;

    state_t                       state_reg, state_next;
    logic [WAIT_W-1:0]            wait_cnt_reg, wait_cnt_next;
    logic                         mem_error_reg;
    logic [STALL_CNT_WIDTH-1:0]   stall_cycles_reg;

    logic [1:0][REG_W-1:0]        id_src;
    logic [1:0]                   id_used;
    logic [1:0]                   ex_hit;
    logic [1:0][1:0]              fwd_sel;
    logic                         hz;
    logic                         mem_stall;

    assign id_src = {id_src2, id_src1};

    // Operand 0 is always read; operand 1 only when the instruction uses two sources.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_id_match
            if (gi == 0) begin : g_first
                assign id_used[gi] = id_valid;
            end else begin : g_second
                assign id_used[gi] = id_valid && id_two_src;
            end
            assign ex_hit[gi] = id_used[gi] && ex_wb_en && (ex_dst == id_src[gi]);
        end
    endgenerate

`ifdef FORWARDING_EN
    logic [1:0][REG_W-1:0] ex_src;
    assign ex_src = {ex_src2, ex_src1};

    // MEM holds the younger result, so it wins over WB.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = (mem_wb_en && (mem_dst == ex_src[gi])) ? 2'd1 :
                                 (wb_wb_en  && (wb_dst  == ex_src[gi])) ? 2'd2 : 2'd0;
        end
    endgenerate

    assign hz = ex_mem_read && (|ex_hit);
`else
    logic [1:0] mem_hit;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_nofwd
            assign mem_hit[gi] = id_used[gi] && mem_wb_en && (mem_dst == id_src[gi]);
            assign fwd_sel[gi] = 2'd0;
        end
    endgenerate

    assign hz = (|ex_hit) || (|mem_hit);

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_src1, ex_src2, wb_dst, wb_wb_en, ex_mem_read};
`endif

    assign mem_stall = (state_reg == ERROR) ? 1'b1 : (mem_req && !mem_ready);

    always_comb begin
        freeze     = 1'b0;
        flush_if   = 1'b0;
        flush_id   = 1'b0;
        freeze_mem = 1'b0;
        fwd_sel1   = 2'd0;
        fwd_sel2   = 2'd0;
        if (!rst) begin
            fwd_sel1 = fwd_sel[0];
            fwd_sel2 = fwd_sel[1];
            if (mem_stall) begin
                freeze     = 1'b1;
                freeze_mem = 1'b1;
            end else if (ex_branch) begin
                flush_if = 1'b1;
                flush_id = 1'b1;
            end else if (hz) begin
                freeze   = 1'b1;
                flush_id = 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (mem_req && !mem_ready) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT)) begin
                    state_next = ERROR;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
                end
            end
            ERROR:   state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            wait_cnt_reg     <= '0;
            mem_error_reg    <= 1'b0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (state_next == ERROR) begin
                mem_error_reg <= 1'b1;
            end
            // Saturate instead of wrapping so long stalls never read as short ones.
            if (freeze && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + STALL_CNT_WIDTH'(1);
            end
        end
    end

    assign mem_error    = mem_error_reg;
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; a second instance with a 2-bit
// stall counter checks saturation.
`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif

module tb_hazard_ctrl;

`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int RW = `REG_FILE_DEPTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_two_src;
    logic [RW-1:0] id_src1, id_src2, ex_dst, ex_src1, ex_src2, mem_dst, wb_dst;
    logic          ex_wb_en, ex_mem_read, ex_branch, mem_wb_en, wb_wb_en;
    logic          mem_req, mem_ready;

    logic          freeze, flush_if, flush_id, freeze_mem, mem_error;
    logic [1:0]    fwd_sel1, fwd_sel2;
    logic [7:0]    stall_cycles;

    logic          s_freeze, s_flush_if, s_flush_id, s_freeze_mem, s_mem_error;
    logic [1:0]    s_fwd_sel1, s_fwd_sel2;
    logic [1:0]    s_stall_cycles;

    logic [3:0]    ctl;
    assign ctl = {freeze, flush_if, flush_id, freeze_mem};

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_src1(ex_src1), .ex_src2(ex_src2), .mem_dst(mem_dst),
        .mem_wb_en(mem_wb_en), .wb_dst(wb_dst), .wb_wb_en(wb_wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .freeze(freeze), .flush_if(flush_if), .flush_id(flush_id),
        .freeze_mem(freeze_mem), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
        .mem_error(mem_error), .stall_cycles(stall_cycles)
    );

    hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .ex_dst(ex_dst), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .ex_branch(ex_branch), .ex_src1(ex_src1), .ex_src2(ex_src2), .mem_dst(mem_dst),
        .mem_wb_en(mem_wb_en), .wb_dst(wb_dst), .wb_wb_en(wb_wb_en), .mem_req(mem_req),
        .mem_ready(mem_ready), .freeze(s_freeze), .flush_if(s_flush_if), .flush_id(s_flush_id),
        .freeze_mem(s_freeze_mem), .fwd_sel1(s_fwd_sel1), .fwd_sel2(s_fwd_sel2),
        .mem_error(s_mem_error), .stall_cycles(s_stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_two_src = 0; id_src1 = '0; id_src2 = '0;
        ex_dst = '0; ex_wb_en = 0; ex_mem_read = 0; ex_branch = 0; ex_src1 = '0; ex_src2 = '0;
        mem_dst = '0; mem_wb_en = 0; wb_dst = '0; wb_wb_en = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_ctl(input string name, input logic [3:0] exp);
        tests++;
        if (ctl !== exp) begin
            $display("FAIL %s: {freeze,flush_if,flush_id,freeze_mem} got %b want %b", name, ctl, exp);
            failed++;
        end else $display("[TB] ok %s ctl=%b", name, ctl);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        id_valid = 1; id_src1 = 3; ex_dst = 3; ex_wb_en = 1; ex_branch = 1;
        mem_req = 1; ex_src1 = 3; mem_dst = 3; mem_wb_en = 1;
        #1;
        check_ctl("reset_ctl", 4'b0000);
        tests++;
        if (fwd_sel1 !== 2'd0) begin
            $display("FAIL reset_fwd: got %0d want 0", fwd_sel1); failed++;
        end else $display("[TB] ok reset_fwd");
        tick();
        tests++;
        if (mem_error !== 1'b0 || stall_cycles !== 8'd0) begin
            $display("FAIL reset_regs: mem_error=%b stall=%0d want 0/0", mem_error, stall_cycles); failed++;
        end else $display("[TB] ok reset_regs");
        rst = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_raw_alu();
        clear_inputs();
        id_valid = 1; id_src1 = 3; ex_dst = 3; ex_wb_en = 1;
        #1 check_ctl("raw_ex_alu", FWD ? 4'b0000 : 4'b1010);
        id_valid = 0;
        #1 check_ctl("raw_invalid", 4'b0000);
        id_valid = 1; ex_wb_en = 0; id_src1 = 7; mem_dst = 7; mem_wb_en = 1;
        #1 check_ctl("raw_mem", FWD ? 4'b0000 : 4'b1010);
        tick();
        clear_inputs();
        ex_src1 = 3; mem_dst = 3; mem_wb_en = 1;
        #1;
        tests++;
        if (fwd_sel1 !== (FWD ? 2'd1 : 2'd0)) begin
            $display("FAIL fwd_mem: fwd_sel1 got %0d want %0d", fwd_sel1, FWD ? 1 : 0); failed++;
        end else $display("[TB] ok fwd_mem fwd_sel1=%0d", fwd_sel1);
        wb_dst = 3; wb_wb_en = 1;
        #1;
        tests++;
        if (fwd_sel1 !== (FWD ? 2'd1 : 2'd0)) begin
            $display("FAIL fwd_prio: fwd_sel1 got %0d want %0d", fwd_sel1, FWD ? 1 : 0); failed++;
        end else $display("[TB] ok fwd_prio fwd_sel1=%0d", fwd_sel1);
        mem_wb_en = 0; ex_src2 = 3;
        #1;
        tests++;
        if (fwd_sel1 !== (FWD ? 2'd2 : 2'd0) || fwd_sel2 !== (FWD ? 2'd2 : 2'd0)) begin
            $display("FAIL fwd_wb: fwd_sel1=%0d fwd_sel2=%0d want %0d", fwd_sel1, fwd_sel2, FWD ? 2 : 0); failed++;
        end else $display("[TB] ok fwd_wb sel1=%0d sel2=%0d", fwd_sel1, fwd_sel2);
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_dst = 5; ex_wb_en = 1; ex_mem_read = 1;
        id_valid = 1; id_src1 = 2; id_src2 = 5; id_two_src = 1;
        #1 check_ctl("load_use", 4'b1010);
        tick();
        // Bubble now in EX, load moved to MEM.
        ex_dst = 0; ex_wb_en = 0; ex_mem_read = 0; mem_dst = 5; mem_wb_en = 1;
        #1 check_ctl("load_after", FWD ? 4'b0000 : 4'b1010);
        ex_dst = 5; ex_wb_en = 1; ex_mem_read = 1; mem_wb_en = 0; id_two_src = 0;
        #1 check_ctl("load_one_src", 4'b0000);
        tick();
    endtask

    task automatic test_branch();
        clear_inputs();
        id_valid = 1; id_src1 = 3; ex_dst = 3; ex_wb_en = 1; ex_mem_read = 1; ex_branch = 1;
        #1 check_ctl("branch_hz", 4'b0110);
        id_valid = 0;
        #1 check_ctl("branch_only", 4'b0110);
        tick();
    endtask

    task automatic test_mem_stall();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (i >= 1) ex_branch = 1;
            #1 check_ctl($sformatf("mem_wait%0d", i), 4'b1001);
            tests++;
            if (stall_cycles !== 8'(i)) begin
                $display("FAIL mem_cnt%0d: stall_cycles got %0d want %0d", i, stall_cycles, i); failed++;
            end else $display("[TB] ok mem_cnt%0d", i);
            tick();
        end
        mem_ready = 1;
        #1 check_ctl("mem_release_branch", 4'b0110);
        tick();
        clear_inputs();
        #1 check_ctl("mem_idle", 4'b0000);
        tests++;
        if (stall_cycles !== 8'd3) begin
            $display("FAIL mem_total: stall_cycles got %0d want 3", stall_cycles); failed++;
        end else $display("[TB] ok mem_total stall_cycles=3");
        tick();
        mem_req = 1; mem_ready = 1;
        #1 check_ctl("mem_fast", 4'b0000);
        tick();
        clear_inputs();
        tests++;
        if (stall_cycles !== 8'd3) begin
            $display("FAIL mem_fast_cnt: stall_cycles got %0d want 3", stall_cycles); failed++;
        end else $display("[TB] ok mem_fast_cnt");
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (mem_error !== 1'b0 || ctl !== 4'b1001) begin
                $display("FAIL to_wait%0d: mem_error=%b ctl=%b want 0/1001", i, mem_error, ctl); failed++;
            end else $display("[TB] ok to_wait%0d", i);
            tick();
        end
        mem_req = 0; mem_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (mem_error !== 1'b1 || ctl !== 4'b1001) begin
                $display("FAIL to_err%0d: mem_error=%b ctl=%b want 1/1001", i, mem_error, ctl); failed++;
            end else $display("[TB] ok to_err%0d", i);
            tick();
        end
        tests++;
        if (stall_cycles !== 8'd8) begin
            $display("FAIL to_cnt: stall_cycles got %0d want 8", stall_cycles); failed++;
        end else $display("[TB] ok to_cnt");
        rst = 1;
        #1 check_ctl("to_rst_forced", 4'b0000);
        tick();
        rst = 0;
        clear_inputs();
        #1;
        tests++;
        if (mem_error !== 1'b0 || stall_cycles !== 8'd0 || ctl !== 4'b0000) begin
            $display("FAIL to_cleared: mem_error=%b stall=%0d ctl=%b want 0/0/0000", mem_error, stall_cycles, ctl); failed++;
        end else $display("[TB] ok to_cleared");
        mem_req = 1; mem_ready = 1;
        #1 check_ctl("to_idle", 4'b0000);
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests++;
            if (s_stall_cycles !== 2'((i > 3) ? 3 : i) || stall_cycles !== 8'(i)) begin
                $display("FAIL sat%0d: narrow=%0d wide=%0d want %0d/%0d", i, s_stall_cycles, stall_cycles, (i > 3) ? 3 : i, i);
                failed++;
            end else $display("[TB] ok sat%0d narrow=%0d", i, s_stall_cycles);
        end
        do_reset();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        test_reset();
        test_raw_alu();
        test_load_use();
        test_branch();
        test_mem_stall();
        test_timeout();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
